// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory bus between the fetch unit and the instruction memory.
//
// Signals
//   imemRe    master->slave  read request; held high for the whole read
//   imemAddr  master->slave  16-bit word address, stable while imemRe=1
//   imemRdy   slave->master  response valid; only asserted while imemRe=1
//   imemData  slave->master  16-bit instruction word, valid with imemRdy
//
// Modports
//   master  the fetch unit
//   slave   the instruction memory (or its model)
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imemRe;
  logic [15:0] imemAddr;
  logic        imemRdy;
  logic [15:0] imemData;

  modport master (
    output imemRe,
    output imemAddr,
    input  imemRdy,
    input  imemData
  );

  modport slave (
    input  imemRe,
    input  imemAddr,
    output imemRdy,
    output imemData
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Single-outstanding-read instruction fetch stage. Issues word reads to the
// instruction memory, presents each fetched word to decode together with
// its address, honours decode stalls and execute-stage redirects, and
// discards the response of a read that a redirect has made stale.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   PCSrc       redirect request from execute (taken branch / jump)
//   targetAddr  redirect destination, valid with PCSrc
//   stall       decode cannot accept an instruction this cycle
//   imem        fetch_unit_if.master: imemRe/imemAddr out, imemRdy/imemData in
//   instrOut    fetched instruction word to decode
//   pcOut       word address of instrOut
//   instrValid  instrOut/pcOut hold a live instruction
//   halted      fetch has stopped on an HLT word
//
// Configuration
//   FETCH_HALT_EN  when defined, a delivered word with opcode 4'hF stops
//                  further reads until a redirect or reset. When undefined,
//                  halted is tied low and 4'hF is an ordinary word.
// ---------------------------------------------------------------------------
module fetch_unit (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCSrc,
  input  logic [15:0]   targetAddr,
  input  logic          stall,
  fetch_unit_if.master  imem,
  output logic [15:0]   instrOut,
  output logic [15:0]   pcOut,
  output logic          instrValid,
  output logic          halted
);

  logic [15:0] pc_q,         pc_d;
  logic        busy_q,       busy_d;
  logic        drop_q,       drop_d;
  logic [15:0] redir_addr_q, redir_addr_d;
  logic [15:0] imem_addr_q,  imem_addr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [15:0] hold_pc_q,    hold_pc_d;
  logic [15:0] instr_out_q,  instr_out_d;
  logic [15:0] pc_out_q,     pc_out_d;
  logic        instr_valid_q, instr_valid_d;

  logic        transfer;
  logic        deliver;
  logic        start_read;
  logic        fetch_halted;

`ifdef FETCH_HALT_EN
  logic        halted_q, halted_d;
  assign fetch_halted = halted_q;
`else
  assign fetch_halted = 1'b0;
`endif

  assign imem.imemRe   = busy_q;
  assign imem.imemAddr = imem_addr_q;
  assign instrOut      = instr_out_q;
  assign pcOut         = pc_out_q;
  assign instrValid    = instr_valid_q;
  assign halted        = fetch_halted;

  // A response completes the outstanding read in any cycle it is presented.
  assign transfer = busy_q & imem.imemRdy;

  // A new read may begin only when nothing is in flight or buffered, fetch
  // is not halted, no redirect is arriving, and the output slot is free or
  // being consumed this cycle.
  assign start_read = !busy_q && !hold_valid_q && !fetch_halted && !PCSrc &&
                      (!instr_valid_q || !stall);

  // Next-state logic. A redirect overrides everything else; otherwise the
  // response path, the decode-consumption path and the read-issue path
  // are evaluated independently.
  always_comb begin
    pc_d          = pc_q;
    busy_d        = busy_q;
    drop_d        = drop_q;
    redir_addr_d  = redir_addr_q;
    imem_addr_d   = imem_addr_q;
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    instr_out_d   = instr_out_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    deliver       = 1'b0;
`ifdef FETCH_HALT_EN
    halted_d      = halted_q;
`endif

    if (PCSrc) begin
      pc_d          = targetAddr;
      instr_valid_d = 1'b0;
      hold_valid_d  = 1'b0;
`ifdef FETCH_HALT_EN
      halted_d      = 1'b0;
`endif
      if (transfer) begin
        // The arriving word is stale; retiring the read here means no
        // later response needs discarding.
        busy_d = 1'b0;
        drop_d = 1'b0;
      end else if (busy_q) begin
        // The read cannot be cancelled on the bus, so remember to discard
        // its response and where to resume; a later redirect overwrites.
        drop_d       = 1'b1;
        redir_addr_d = targetAddr;
      end
    end else begin
      if (transfer) begin
        busy_d = 1'b0;
        if (drop_q) begin
          pc_d   = redir_addr_q;
          drop_d = 1'b0;
        end else begin
          pc_d    = imem_addr_q + 16'd1;
          deliver = 1'b1;
`ifdef FETCH_HALT_EN
          if (imem.imemData[15:12] == 4'hF) begin
            halted_d = 1'b1;
          end
`endif
        end
      end

      if (deliver && (!stall || !instr_valid_q)) begin
        instr_out_d   = imem.imemData;
        pc_out_d      = imem_addr_q;
        instr_valid_d = 1'b1;
      end else if (deliver) begin
        hold_valid_d = 1'b1;
        hold_instr_d = imem.imemData;
        hold_pc_d    = imem_addr_q;
      end else if (!stall) begin
        if (hold_valid_q) begin
          instr_out_d   = hold_instr_q;
          pc_out_d      = hold_pc_q;
          instr_valid_d = 1'b1;
          hold_valid_d  = 1'b0;
        end else begin
          instr_valid_d = 1'b0;
        end
      end

      if (start_read) begin
        busy_d      = 1'b1;
        imem_addr_d = pc_q;
      end
    end
  end

  // State register with synchronous reset; reset also abandons any read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= 16'h0000;
      busy_q        <= 1'b0;
      drop_q        <= 1'b0;
      redir_addr_q  <= 16'h0000;
      imem_addr_q   <= 16'h0000;
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= 16'h0000;
      hold_pc_q     <= 16'h0000;
      instr_out_q   <= 16'h0000;
      pc_out_q      <= 16'h0000;
      instr_valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      busy_q        <= busy_d;
      drop_q        <= drop_d;
      redir_addr_q  <= redir_addr_d;
      imem_addr_q   <= imem_addr_d;
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_HALT_EN
      halted_q      <= halted_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A behavioural instruction memory answers
// reads after a programmable number of wait cycles with word addr+0x1000
// (or 0xF000 at address 0x0003 when haltWord is set).
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc;
  logic [15:0] targetAddr;
  logic        stall;
  logic [15:0] instrOut;
  logic [15:0] pcOut;
  logic        instrValid;
  logic        halted;

  int compared   = 0;
  int mismatched = 0;
  int lat        = 0;
  int waitCnt    = 0;
  bit haltWord   = 1'b0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc      (PCSrc),
    .targetAddr (targetAddr),
    .stall      (stall),
    .imem       (bus.master),
    .instrOut   (instrOut),
    .pcOut      (pcOut),
    .instrValid (instrValid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Memory model: responds in the cycle after lat wait cycles of imemRe.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (haltWord && a == 16'h0003) return 16'hF000;
    return a + 16'h1000;
  endfunction

  assign bus.imemRdy  = bus.imemRe && (waitCnt == lat);
  assign bus.imemData = memWord(bus.imemAddr);

  always @(posedge clk) begin
    if (rst || !bus.imemRe || bus.imemRdy) waitCnt <= 0;
    else                                    waitCnt <= waitCnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic pcs,
                               input logic [15:0] tgt, input logic st);
    rst        = r;
    PCSrc      = pcs;
    targetAddr = tgt;
    stall      = st;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Ticks until instrValid rises, bounded by maxCycles.
  task automatic waitValid(input string tag, input int maxCycles);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!instrValid && n < maxCycles);
    checkOutput({tag, "_valid"}, {15'd0, instrValid}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    tick(); tick(); tick();

    // Reset state
    checkOutput("rst_re",     {15'd0, bus.imemRe}, 16'd0);
    checkOutput("rst_addr",   bus.imemAddr,        16'h0000);
    checkOutput("rst_valid",  {15'd0, instrValid}, 16'd0);
    checkOutput("rst_pcOut",  pcOut,               16'h0000);
    checkOutput("rst_instr",  instrOut,            16'h0000);
    checkOutput("rst_halted", {15'd0, halted},     16'd0);

    // Zero-wait streaming: first read at 0x0000 right after reset
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("first_re",   {15'd0, bus.imemRe}, 16'd1);
    checkOutput("first_addr", bus.imemAddr,        16'h0000);
    tick();
    checkOutput("s0_valid", {15'd0, instrValid}, 16'd1);
    checkOutput("s0_pc",    pcOut,               16'h0000);
    checkOutput("s0_instr", instrOut,            16'h1000);
    tick();
    checkOutput("s0_gap",   {15'd0, instrValid}, 16'd0);
    checkOutput("s1_addr",  bus.imemAddr,        16'h0001);
    tick();
    checkOutput("s1_pc",    pcOut,               16'h0001);
    checkOutput("s1_instr", instrOut,            16'h1001);
    tick(); tick();
    checkOutput("s2_valid", {15'd0, instrValid}, 16'd1);
    checkOutput("s2_pc",    pcOut,               16'h0002);
    checkOutput("s2_instr", instrOut,            16'h1002);
    for (int k = 3; k <= 5; k++) begin
      tick(); tick();
      checkOutput("stream_pc", pcOut, 16'(k));
    end

    // Stall while 0x0005 is presented: output holds, no read issued
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("stall_pc",    pcOut,               16'h0005);
      checkOutput("stall_valid", {15'd0, instrValid}, 16'd1);
      checkOutput("stall_re",    {15'd0, bus.imemRe}, 16'd0);
    end
    // 0x0005 consumed, read of 0x0006 issued, then stall during the read
    lat = 2;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("st6_gap",  {15'd0, instrValid}, 16'd0);
    checkOutput("st6_addr", bus.imemAddr,        16'h0006);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    tick(); tick(); tick(); tick();
    checkOutput("st6_pc",    pcOut,               16'h0006);
    checkOutput("st6_instr", instrOut,            16'h1006);
    checkOutput("st6_re",    {15'd0, bus.imemRe}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("st7_gap",  {15'd0, instrValid}, 16'd0);
    checkOutput("st7_addr", bus.imemAddr,        16'h0007);
    waitValid("st7", 10);
    checkOutput("st7_pc", pcOut, 16'h0007);

    // Redirect during a slow read: response of 0x0010 discarded
    lat = 3;
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("r10_flush", {15'd0, instrValid}, 16'd0);
    tick();
    checkOutput("r10_addr", bus.imemAddr, 16'h0010);
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("r10_hold", bus.imemAddr, 16'h0010);
      tick();
    end
    checkOutput("r10_drop", {15'd0, instrValid}, 16'd0);
    checkOutput("r10_idle", {15'd0, bus.imemRe}, 16'd0);
    tick();
    checkOutput("r40_addr", bus.imemAddr, 16'h0040);
    waitValid("r40", 10);
    checkOutput("r40_pc",    pcOut,    16'h0040);
    checkOutput("r40_instr", instrOut, 16'h1040);

    // Redirect coincident with a response while stalled
    lat = 1;
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b1);
    tick();
    checkOutput("r20_flush", {15'd0, instrValid}, 16'd0);
    checkOutput("r20_idle",  {15'd0, bus.imemRe}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    waitValid("r20", 10);
    checkOutput("r20_pc",    pcOut,    16'h0020);
    checkOutput("r20_instr", instrOut, 16'h1020);

    // Address wrap at 0xFFFF
    lat = 0;
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    waitValid("wrap", 10);
    checkOutput("wrap_pc",    pcOut,    16'hFFFF);
    checkOutput("wrap_instr", instrOut, 16'h0FFF);
    tick();
    checkOutput("wrap_addr", bus.imemAddr,        16'h0000);
    checkOutput("wrap_re",   {15'd0, bus.imemRe}, 16'd1);
    tick();
    checkOutput("wrap_next", instrOut, 16'h1000);

    // Opcode 4'hF at 0x0003
    haltWord = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0003, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    waitValid("hlt", 10);
    checkOutput("hlt_pc",    pcOut,    16'h0003);
    checkOutput("hlt_instr", instrOut, 16'hF000);
`ifdef FETCH_HALT_EN
    checkOutput("hlt_halted", {15'd0, halted}, 16'd1);
    tick();
    checkOutput("hlt_gone", {15'd0, instrValid}, 16'd0);
    tick();
    checkOutput("hlt_re",     {15'd0, bus.imemRe}, 16'd0);
    checkOutput("hlt_stay",   {15'd0, halted},     16'd1);
    applyStimulus(1'b0, 1'b1, 16'h0008, 1'b0);
    tick();
    checkOutput("hlt_clear", {15'd0, halted}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    waitValid("res8", 10);
    checkOutput("res8_pc",    pcOut,    16'h0008);
    checkOutput("res8_instr", instrOut, 16'h1008);
`else
    checkOutput("nohlt_halted", {15'd0, halted}, 16'd0);
    tick();
    checkOutput("nohlt_re",   {15'd0, bus.imemRe}, 16'd1);
    checkOutput("nohlt_addr", bus.imemAddr,        16'h0004);
    waitValid("nohlt4", 10);
    checkOutput("nohlt4_pc", pcOut, 16'h0004);
`endif
    haltWord = 1'b0;

    // Reset during an outstanding read
    lat = 3;
    tick();
    checkOutput("rb_re", {15'd0, bus.imemRe}, 16'd1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("rb_re0",    {15'd0, bus.imemRe}, 16'd0);
    checkOutput("rb_addr0",  bus.imemAddr,        16'h0000);
    checkOutput("rb_valid0", {15'd0, instrValid}, 16'd0);
    checkOutput("rb_pc0",    pcOut,               16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("rb_first", bus.imemAddr,        16'h0000);
    checkOutput("rb_re1",   {15'd0, bus.imemRe}, 16'd1);
    waitValid("rb", 10);
    checkOutput("rb_pc",    pcOut,    16'h0000);
    checkOutput("rb_instr", instrOut, 16'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
